dcache_req_fifo: RTL and testbench
==================================

DCACHE_REQ_FIFO -- requirements
Module: dcache_req_fifo

Interface
REQ-001 SHALL have parameter DATABITS, default 32, request data width.
REQ-002 SHALL have parameter ADDRBITS, default 32, request address width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports queue_in_data/queue_in_addr/queue_in_rdreq/queue_in_wrreq  input  DATABITS/ADDRBITS/1/1  entry to enqueue.
REQ-007 SHALL have port queue_push  input  1  enqueue strobe.
REQ-008 SHALL have port queue_pop  input  1  dequeue strobe.
REQ-009 SHALL have ports queue_out_data/queue_out_addr/queue_out_rdreq/queue_out_wrreq  output  DATABITS/ADDRBITS/1/1  head entry.
REQ-010 SHALL have port queue_not_empty  output  1  at least one entry held.
REQ-011 SHALL have port queue_full  output  1  DEPTH entries held.
REQ-012 SHALL have port queue_level  output  $clog2(DEPTH)+1  entries held.
REQ-013 SHALL have ports queue_overflow, queue_underflow  output  1 each  one-cycle error pulses.
REQ-014 SHALL have ports lookup_addr (input ADDRBITS), lookup_hit (output 1), lookup_data (output DATABITS), present only per REQ-031.

Function
REQ-015 Head outputs SHALL be show-ahead: queue_out_* driven from the head entry with no registered read latency; all zero when empty.
REQ-016 Push SHALL store queue_in_* at the tail on the clk edge where queue_push=1 and (not full, or queue_pop=1).
REQ-017 Pop SHALL advance head on the clk edge where queue_pop=1 and not empty; the next entry appears on queue_out_* the same edge.
REQ-018 Push and pop together when 1..DEPTH-1 held: both occur, level unchanged.
REQ-019 Push and pop together when full: both occur (push-through), level stays DEPTH, no overflow.
REQ-020 Push and pop together when empty: push only, queue_underflow pulses, new entry visible next cycle.
REQ-021 Push when full without pop: entry dropped, contents unchanged, queue_overflow=1 for exactly the following cycle.
REQ-022 Pop when empty without push: no state change, queue_underflow=1 for exactly the following cycle.
REQ-023 Pointers SHALL be $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; full/empty from queue_level, never pointer equality alone.
REQ-024 queue_not_empty = (queue_level!=0); queue_full = (queue_level==DEPTH); both combinational from registered level.
REQ-025 queue_in_rdreq and queue_in_wrreq SHALL be stored verbatim; both-set and both-clear entries are legal.

Reset
REQ-026 reset_n low SHALL asynchronously clear pointers, queue_level, queue_overflow, queue_underflow.
REQ-027 During/after reset: queue_not_empty=0, queue_full=0, queue_out_*=0, lookup_hit=0.
REQ-028 Reset mid-operation SHALL discard all entries; storage array need not be cleared.
REQ-029 First push SHALL be accepted on the first clk edge after reset_n rises.

Configuration
REQ-030 Macro DCACHE_REQ_FIFO_LOOKUP_EN SHALL select store-forward lookup.
REQ-031 With it defined: lookup ports exist; lookup_hit=1 combinationally when any held entry has wrreq=1 and addr==lookup_addr; lookup_data = data of youngest such entry; else lookup_hit=0, lookup_data=0.
REQ-032 Without it: lookup ports and compare logic absent; all other behaviour identical.

Structure
REQ-033 Shared package dcache_pkg SHALL hold the entry typedef (data, addr, rdreq, wrreq) and level-width helper constant.
REQ-034 One sub-module dcache_req_fifo_lookup SHALL implement the youngest-match priority search, instantiated only under the macro.

Verification
REQ-035 Reset, push {data=32'hd00faffe, addr=32'hdeadbeef, wr=1} -> next cycle not_empty=1, level=1, queue_out_data=32'hd00faffe; pop -> not_empty=0, outputs 0.
REQ-036 DEPTH=4: push 1,2,3,4 -> full=1, level=4; push 5 -> overflow pulse one cycle; four pops yield 1,2,3,4 in order.
REQ-037 Full, push 9 with pop -> head 2, tail 9, level=4, no overflow; continue 8 push/pop pairs across wrap -> order preserved.
REQ-038 Empty, push and pop same edge -> underflow pulse, level=1; pop alone on empty -> underflow pulse, level unchanged.
REQ-039 Macro on: push wr addr 0x100 data 0xA, then wr addr 0x100 data 0xB, rd addr 0x100 -> lookup_addr 0x100 gives hit=1, data=0xB; lookup 0x104 -> hit=0.
REQ-040 Three entries held, reset_n pulsed low between edges -> outputs clear immediately; level=0 after release.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the data-cache request path.
// Holds the request entry layout and the level-width helper used by
// dcache_req_fifo and its optional lookup block.
// Entry field widths below are the widest widths the FIFO can carry.
package dcache_pkg;

   localparam int unsigned DCACHE_DATABITS = 32;
   localparam int unsigned DCACHE_ADDRBITS = 32;

   // One queued cache request; rdreq and wrreq are independent flags
   typedef struct packed {
      logic [DCACHE_DATABITS-1:0] data;
      logic [DCACHE_ADDRBITS-1:0] addr;
      logic                       rdreq;
      logic                       wrreq;
   } dcache_req_t;

   // Occupancy counter width: must represent 0..depth inclusive
   function automatic int unsigned dcache_level_bits(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int unsigned DCACHE_DEFAULT_DEPTH      = 4;
   localparam int unsigned DCACHE_DEFAULT_LEVEL_BITS = dcache_level_bits(DCACHE_DEFAULT_DEPTH);

endpackage

// File: rtl/dcache_req_fifo_lookup.sv
// Store-forward search over the held FIFO entries.
// Reports the youngest held write whose address matches lookup_addr.
// Only instantiated when DCACHE_REQ_FIFO_LOOKUP_EN is defined.
module dcache_req_fifo_lookup
   import dcache_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned DATABITS = 32,
   parameter int unsigned ADDRBITS = 32
) (
   input  dcache_req_t               entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]  rd_ptr,
   input  logic [$clog2(DEPTH):0]    level,
   input  logic [ADDRBITS-1:0]       lookup_addr,
   output logic                      lookup_hit,
   output logic [DATABITS-1:0]       lookup_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = dcache_level_bits(DEPTH);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so a later match overrides an earlier one
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      idx         = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if ((LVL_W'(i) < level) && entries[idx].wrreq &&
             (entries[idx].addr == DCACHE_ADDRBITS'(lookup_addr))) begin
            lookup_hit  = 1'b1;
            lookup_data = DATABITS'(entries[idx].data);
         end
      end
   end

endmodule

// File: rtl/dcache_req_fifo.sv
// Show-ahead request FIFO for the data cache.
// Head entry is presented combinationally; push-through is allowed when full,
// and overflow/underflow misuse is flagged with one-cycle pulses.
// Optional store-forward lookup: define DCACHE_REQ_FIFO_LOOKUP_EN.
module dcache_req_fifo
   import dcache_pkg::*;
#(
   parameter int unsigned DATABITS = DCACHE_DATABITS,
   parameter int unsigned ADDRBITS = DCACHE_ADDRBITS,
   parameter int unsigned DEPTH    = DCACHE_DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [DATABITS-1:0]      queue_in_data,
   input  logic [ADDRBITS-1:0]      queue_in_addr,
   input  logic                     queue_in_rdreq,
   input  logic                     queue_in_wrreq,
   input  logic                     queue_push,
   input  logic                     queue_pop,
   output logic [DATABITS-1:0]      queue_out_data,
   output logic [ADDRBITS-1:0]      queue_out_addr,
   output logic                     queue_out_rdreq,
   output logic                     queue_out_wrreq,
   output logic                     queue_not_empty,
   output logic                     queue_full,
   output logic [$clog2(DEPTH):0]   queue_level,
   output logic                     queue_overflow,
   output logic                     queue_underflow
`ifdef DCACHE_REQ_FIFO_LOOKUP_EN
   ,
   input  logic [ADDRBITS-1:0]      lookup_addr,
   output logic                     lookup_hit,
   output logic [DATABITS-1:0]      lookup_data
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = dcache_level_bits(DEPTH);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   dcache_req_t      mem [DEPTH];
   dcache_req_t      in_entry;
   dcache_req_t      head;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [LVL_W-1:0] level;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Full/empty come from the occupancy count, since rd_ptr == wr_ptr is ambiguous
   assign empty   = (level == '0);
   assign full    = (level == LVL_FULL);
   // A pop frees the slot on the same edge, so a full FIFO still accepts a push with pop
   assign do_push = queue_push && (!full || queue_pop);
   assign do_pop  = queue_pop && !empty;

   // Pack the incoming request into the shared entry layout
   always_comb begin
      in_entry       = '0;
      in_entry.data  = DCACHE_DATABITS'(queue_in_data);
      in_entry.addr  = DCACHE_ADDRBITS'(queue_in_addr);
      in_entry.rdreq = queue_in_rdreq;
      in_entry.wrreq = queue_in_wrreq;
   end

   // Show-ahead head: zero whenever nothing is held
   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr];
   end

   assign queue_out_data  = DATABITS'(head.data);
   assign queue_out_addr  = ADDRBITS'(head.addr);
   assign queue_out_rdreq = head.rdreq;
   assign queue_out_wrreq = head.wrreq;
   assign queue_not_empty = !empty;
   assign queue_full      = full;
   assign queue_level     = level;

   // Entry storage is data only; reset discards entries by clearing the level
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= in_entry;
   end

   // Pointers, occupancy and error pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         level           <= '0;
         queue_overflow  <= 1'b0;
         queue_underflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         queue_overflow  <= queue_push && full && !queue_pop;
         queue_underflow <= queue_pop && empty;
      end
   end

`ifdef DCACHE_REQ_FIFO_LOOKUP_EN
   // Forwarding search over held entries
   dcache_req_fifo_lookup #(
      .DEPTH    (DEPTH),
      .DATABITS (DATABITS),
      .ADDRBITS (ADDRBITS)
   ) u_lookup (
      .entries     (mem),
      .rd_ptr      (rd_ptr),
      .level       (level),
      .lookup_addr (lookup_addr),
      .lookup_hit  (lookup_hit),
      .lookup_data (lookup_data)
   );
`else
   // No forwarding path: held entries are visible only at the head
`endif

endmodule

// File: tb/tb_dcache_req_fifo.sv
// Directed self-checking bench for dcache_req_fifo (DEPTH=4).
// Lookup scenario is exercised when DCACHE_REQ_FIFO_LOOKUP_EN is defined.
module tb_dcache_req_fifo;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] queue_in_data = '0;
   logic [31:0] queue_in_addr = '0;
   logic        queue_in_rdreq = 1'b0;
   logic        queue_in_wrreq = 1'b0;
   logic        queue_push = 1'b0;
   logic        queue_pop = 1'b0;
   logic [31:0] queue_out_data;
   logic [31:0] queue_out_addr;
   logic        queue_out_rdreq;
   logic        queue_out_wrreq;
   logic        queue_not_empty;
   logic        queue_full;
   logic [2:0]  queue_level;
   logic        queue_overflow;
   logic        queue_underflow;
`ifdef DCACHE_REQ_FIFO_LOOKUP_EN
   logic [31:0] lookup_addr = '0;
   logic        lookup_hit;
   logic [31:0] lookup_data;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dcache_req_fifo #(.DATABITS(32), .ADDRBITS(32), .DEPTH(4)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .queue_in_data   (queue_in_data),
      .queue_in_addr   (queue_in_addr),
      .queue_in_rdreq  (queue_in_rdreq),
      .queue_in_wrreq  (queue_in_wrreq),
      .queue_push      (queue_push),
      .queue_pop       (queue_pop),
      .queue_out_data  (queue_out_data),
      .queue_out_addr  (queue_out_addr),
      .queue_out_rdreq (queue_out_rdreq),
      .queue_out_wrreq (queue_out_wrreq),
      .queue_not_empty (queue_not_empty),
      .queue_full      (queue_full),
      .queue_level     (queue_level),
      .queue_overflow  (queue_overflow),
      .queue_underflow (queue_underflow)
`ifdef DCACHE_REQ_FIFO_LOOKUP_EN
      ,
      .lookup_addr     (lookup_addr),
      .lookup_hit      (lookup_hit),
      .lookup_data     (lookup_data)
`endif
   );

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic push, input logic pop, input logic [31:0] data,
                        input logic [31:0] addr, input logic rd, input logic wr);
      queue_push     = push;
      queue_pop      = pop;
      queue_in_data  = data;
      queue_in_addr  = addr;
      queue_in_rdreq = rd;
      queue_in_wrreq = wr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      idle();
      reset_n = 1'b0;
      step();
      step();
      tests_run++; if (queue_not_empty !== 1'b0) begin tests_failed++; $display("FAIL reset_not_empty: got %0b expected 0", queue_not_empty); end
      tests_run++; if (queue_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %0b expected 0", queue_full); end
      tests_run++; if (queue_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", queue_level); end
      tests_run++; if (queue_out_data !== 32'h0 || queue_out_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_out: got data %h addr %h expected 0 0", queue_out_data, queue_out_addr); end
      tests_run++; if (queue_overflow !== 1'b0 || queue_underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got ovf %0b unf %0b expected 0 0", queue_overflow, queue_underflow); end
`ifdef DCACHE_REQ_FIFO_LOOKUP_EN
      tests_run++; if (lookup_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_lookup_hit: got %0b expected 0", lookup_hit); end
`endif
      // Release between edges; the very next edge must accept a push
      #3 reset_n = 1'b1;
      drive(1'b1, 1'b0, 32'h0000_0077, 32'h0000_0070, 1'b1, 1'b0);
      step();
      tests_run++; if (queue_level !== 3'd1 || queue_out_data !== 32'h77) begin tests_failed++; $display("FAIL first_push: got level %0d data %h expected 1 77", queue_level, queue_out_data); end
      drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      idle();
      tests_run++; if (queue_level !== 3'd0) begin tests_failed++; $display("FAIL first_push_drain: got level %0d expected 0", queue_level); end
   endtask

   task automatic test_single();
      drive(1'b1, 1'b0, 32'hd00faffe, 32'hdeadbeef, 1'b0, 1'b1);
      step();
      idle();
      tests_run++; if (queue_not_empty !== 1'b1 || queue_level !== 3'd1) begin tests_failed++; $display("FAIL single_occupancy: got ne %0b level %0d expected 1 1", queue_not_empty, queue_level); end
      tests_run++; if (queue_out_data !== 32'hd00faffe || queue_out_addr !== 32'hdeadbeef) begin tests_failed++; $display("FAIL single_head: got %h/%h expected d00faffe/deadbeef", queue_out_data, queue_out_addr); end
      tests_run++; if (queue_out_wrreq !== 1'b1 || queue_out_rdreq !== 1'b0) begin tests_failed++; $display("FAIL single_flags: got rd %0b wr %0b expected 0 1", queue_out_rdreq, queue_out_wrreq); end
      drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      idle();
      tests_run++; if (queue_not_empty !== 1'b0) begin tests_failed++; $display("FAIL single_pop_empty: got %0b expected 0", queue_not_empty); end
      tests_run++; if (queue_out_data !== 32'h0 || queue_out_addr !== 32'h0 || queue_out_wrreq !== 1'b0) begin tests_failed++; $display("FAIL single_pop_out: got %h/%h/%0b expected 0/0/0", queue_out_data, queue_out_addr, queue_out_wrreq); end
   endtask

   task automatic test_fill_overflow();
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 1'b0, 32'(k), 32'(k * 16), 1'b1, 1'b0);
         step();
      end
      idle();
      tests_run++; if (queue_full !== 1'b1 || queue_level !== 3'd4) begin tests_failed++; $display("FAIL fill_full: got full %0b level %0d expected 1 4", queue_full, queue_level); end
      drive(1'b1, 1'b0, 32'd5, 32'd80, 1'b1, 1'b0);
      step();
      idle();
      tests_run++; if (queue_overflow !== 1'b1 || queue_level !== 3'd4) begin tests_failed++; $display("FAIL overflow_pulse: got ovf %0b level %0d expected 1 4", queue_overflow, queue_level); end
      step();
      tests_run++; if (queue_overflow !== 1'b0) begin tests_failed++; $display("FAIL overflow_one_cycle: got %0b expected 0", queue_overflow); end
      for (int k = 1; k <= 4; k++) begin
         tests_run++; if (queue_out_data !== 32'(k) || queue_out_addr !== 32'(k * 16)) begin tests_failed++; $display("FAIL drain_order_%0d: got %h/%h expected %h/%h", k, queue_out_data, queue_out_addr, k, k * 16); end
         drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
         step();
      end
      idle();
      tests_run++; if (queue_not_empty !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got %0b expected 0", queue_not_empty); end
   endtask

   task automatic test_push_through();
      logic [31:0] exp_heads [8];
      exp_heads = '{32'd2, 32'd3, 32'd4, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13};
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 1'b0, 32'(k), 32'(k), 1'b0, 1'b1);
         step();
      end
      drive(1'b1, 1'b1, 32'd9, 32'd9, 1'b0, 1'b1);
      step();
      idle();
      tests_run++; if (queue_out_data !== 32'd2 || queue_level !== 3'd4) begin tests_failed++; $display("FAIL pushthru_head: got head %0d level %0d expected 2 4", queue_out_data, queue_level); end
      tests_run++; if (queue_overflow !== 1'b0 || queue_full !== 1'b1) begin tests_failed++; $display("FAIL pushthru_flags: got ovf %0b full %0b expected 0 1", queue_overflow, queue_full); end
      for (int k = 0; k < 8; k++) begin
         tests_run++; if (queue_out_data !== exp_heads[k]) begin tests_failed++; $display("FAIL wrap_head_%0d: got %0d expected %0d", k, queue_out_data, exp_heads[k]); end
         drive(1'b1, 1'b1, 32'(10 + k), 32'(10 + k), 1'b0, 1'b1);
         step();
      end
      idle();
      tests_run++; if (queue_level !== 3'd4 || queue_overflow !== 1'b0) begin tests_failed++; $display("FAIL wrap_level: got level %0d ovf %0b expected 4 0", queue_level, queue_overflow); end
      for (int k = 14; k <= 17; k++) begin
         tests_run++; if (queue_out_data !== 32'(k)) begin tests_failed++; $display("FAIL wrap_drain_%0d: got %0d expected %0d", k, queue_out_data, k); end
         drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
         step();
      end
      idle();
      tests_run++; if (queue_level !== 3'd0) begin tests_failed++; $display("FAIL wrap_drain_level: got %0d expected 0", queue_level); end
   endtask

   task automatic test_empty_push_pop();
      drive(1'b1, 1'b1, 32'h0000_00c3, 32'h0000_0300, 1'b1, 1'b1);
      step();
      idle();
      tests_run++; if (queue_underflow !== 1'b1 || queue_level !== 3'd1) begin tests_failed++; $display("FAIL empty_pushpop: got unf %0b level %0d expected 1 1", queue_underflow, queue_level); end
      tests_run++; if (queue_out_data !== 32'hc3) begin tests_failed++; $display("FAIL empty_pushpop_head: got %h expected c3", queue_out_data); end
      drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      tests_run++; if (queue_underflow !== 1'b0 || queue_level !== 3'd0) begin tests_failed++; $display("FAIL unf_clear: got unf %0b level %0d expected 0 0", queue_underflow, queue_level); end
      step();
      idle();
      tests_run++; if (queue_underflow !== 1'b1 || queue_level !== 3'd0) begin tests_failed++; $display("FAIL pop_empty: got unf %0b level %0d expected 1 0", queue_underflow, queue_level); end
      step();
      tests_run++; if (queue_underflow !== 1'b0) begin tests_failed++; $display("FAIL pop_empty_one_cycle: got %0b expected 0", queue_underflow); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 32'h0000_0011, 32'h0000_0110, 1'b1, 1'b1);
      step();
      drive(1'b1, 1'b0, 32'h0000_0022, 32'h0000_0220, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b0, 32'h0000_0033, 32'h0000_0330, 1'b0, 1'b1);
      step();
      idle();
      tests_run++; if (queue_level !== 3'd3 || queue_out_rdreq !== 1'b1 || queue_out_wrreq !== 1'b1) begin tests_failed++; $display("FAIL mid_held: got level %0d rd %0b wr %0b expected 3 1 1", queue_level, queue_out_rdreq, queue_out_wrreq); end
      #2 reset_n = 1'b0;
      #1;
      tests_run++; if (queue_not_empty !== 1'b0 || queue_level !== 3'd0) begin tests_failed++; $display("FAIL mid_async_clear: got ne %0b level %0d expected 0 0", queue_not_empty, queue_level); end
      tests_run++; if (queue_out_data !== 32'h0 || queue_out_rdreq !== 1'b0) begin tests_failed++; $display("FAIL mid_async_out: got data %h rd %0b expected 0 0", queue_out_data, queue_out_rdreq); end
      #1 reset_n = 1'b1;
      step();
      tests_run++; if (queue_level !== 3'd0 || queue_not_empty !== 1'b0) begin tests_failed++; $display("FAIL mid_after_release: got level %0d ne %0b expected 0 0", queue_level, queue_not_empty); end
   endtask

`ifdef DCACHE_REQ_FIFO_LOOKUP_EN
   task automatic test_lookup();
      drive(1'b1, 1'b0, 32'h0000_000A, 32'h0000_0100, 1'b0, 1'b1);
      step();
      drive(1'b1, 1'b0, 32'h0000_000B, 32'h0000_0100, 1'b0, 1'b1);
      step();
      drive(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b1, 1'b0);
      step();
      idle();
      lookup_addr = 32'h0000_0100;
      #1;
      tests_run++; if (lookup_hit !== 1'b1 || lookup_data !== 32'hB) begin tests_failed++; $display("FAIL lookup_youngest: got hit %0b data %h expected 1 b", lookup_hit, lookup_data); end
      lookup_addr = 32'h0000_0104;
      #1;
      tests_run++; if (lookup_hit !== 1'b0 || lookup_data !== 32'h0) begin tests_failed++; $display("FAIL lookup_miss: got hit %0b data %h expected 0 0", lookup_hit, lookup_data); end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
         step();
      end
      idle();
      lookup_addr = 32'h0000_0100;
      #1;
      tests_run++; if (lookup_hit !== 1'b0) begin tests_failed++; $display("FAIL lookup_after_drain: got %0b expected 0", lookup_hit); end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_push_through();
      test_empty_push_pop();
      test_reset_mid();
`ifdef DCACHE_REQ_FIFO_LOOKUP_EN
      test_lookup();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
